// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 delay/sound timer block.
// Timer select encoding and register width live here.
package chip8_pkg;

  localparam int TIMER_W = 8;

  localparam logic TIMER_SEL_DELAY = 1'b0;
  localparam logic TIMER_SEL_SOUND = 1'b1;

  function automatic int div_width(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/chip8_countdown.sv
// One 60 Hz countdown: load, tick, hold, saturate at 0.
// Pulses expired_o in the cycle the value first reads 0 after a tick.
module chip8_countdown
  import chip8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] data_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] value_o,
  output logic               expired_o
);

  logic [TIMER_W-1:0] val_q, val_d;
  logic               exp_q, exp_d;
  logic               dec;

  // A load always wins over a tick in the same cycle.
  assign dec = tick_i && !load_i && (val_q != '0);

  always_comb begin
    val_d = val_q;
    exp_d = 1'b0;
    if (load_i) begin
      val_d = data_i;
    end else if (dec) begin
      val_d = val_q - 1'b1;
      exp_d = (val_q == TIMER_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      exp_q <= 1'b0;
    end else begin
      val_q <= val_d;
      exp_q <= exp_d;
    end
  end

  assign value_o   = val_q;
  assign expired_o = exp_q;

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers with optional square-wave beeper.
// Define CHIP8_BEEP_EN to build the beeper; otherwise beep_out is 0.
module chip8_timers
  import chip8_pkg::*;
#(
  parameter int CLOCK_HZ = 12000000,
  parameter int BEEP_HZ  = 440
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_60hz,
  input  logic               pause,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] delay_value,
  output logic [TIMER_W-1:0] sound_value,
  output logic               sound_active,
  output logic               delay_expired,
  output logic               beep_out
);

  logic tick_en;
  logic ld_delay, ld_sound;
  logic snd_expired_unused;

  assign tick_en  = tick_60hz && !pause;
  assign ld_delay = wr_en && (wr_sel == TIMER_SEL_DELAY);
  assign ld_sound = wr_en && (wr_sel == TIMER_SEL_SOUND);

  chip8_countdown u_delay (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ld_delay),
    .data_i    (wr_data),
    .tick_i    (tick_en),
    .value_o   (delay_value),
    .expired_o (delay_expired)
  );

  chip8_countdown u_sound (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ld_sound),
    .data_i    (wr_data),
    .tick_i    (tick_en),
    .value_o   (sound_value),
    .expired_o (snd_expired_unused)
  );

  assign sound_active = (sound_value != '0);

`ifdef CHIP8_BEEP_EN
  localparam int HALF  = CLOCK_HZ / (2 * BEEP_HZ);
  localparam int DIV_W = div_width(HALF);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             beep_q, beep_d;

  // Silence parks the divider at its top so every tone starts in phase.
  always_comb begin
    div_d  = div_q;
    beep_d = beep_q;
    if (!sound_active) begin
      div_d  = DIV_TOP;
      beep_d = 1'b0;
    end else if (div_q == '0) begin
      div_d  = DIV_TOP;
      beep_d = !beep_q;
    end else begin
      div_d  = div_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= DIV_TOP;
      beep_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      beep_q <= beep_d;
    end
  end

  assign beep_out = beep_q;
`else
  assign beep_out = 1'b0;
`endif

endmodule
